dcs_host: RTL and testbench

DCS_HOST -- requirements
Module: dcs_host

---
 rtl/dcs_host.sv | 232 +++++++++++++++++++++++
 tb/tb_dcs_host.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcs_host.sv
// dcs_host: host-side sequencer for the accelerator. It streams 128 input
// bytes, waits for w_ready, then streams 8 weight bytes and collects 8
// 32-bit result words into a readback buffer.
// Optional feature: define DCS_TIMEOUT_EN to add a 6-bit watchdog on the
// two wait states (WAIT_WR, WAIT_O) that aborts to IDLE and sets timeout_err.
module dcs_host (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ld_en,
    input  logic [7:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic [2:0]  res_addr,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        i_valid,
    output logic [7:0]  i_data,
    input  logic        w_ready,
    output logic        w_valid,
    output logic [7:0]  w_data,
    input  logic        o_valid,
    input  logic [31:0] o_data
);

    localparam int unsigned I_DEPTH = 128;
    localparam int unsigned W_DEPTH = 8;
    localparam int unsigned R_DEPTH = 8;
    localparam int unsigned I_AW    = 7;
    localparam int unsigned W_AW    = 3;
    localparam int unsigned R_AW    = 3;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_I  = 3'd1;
    localparam logic [2:0] S_WAIT_WR = 3'd2;
    localparam logic [2:0] S_SEND_W  = 3'd3;
    localparam logic [2:0] S_WAIT_O  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [I_AW-1:0]   i_cnt;
    logic [I_AW-1:0]   i_cnt_nxt;
    logic [W_AW-1:0]   w_cnt;
    logic [W_AW-1:0]   w_cnt_nxt;
    logic [R_AW-1:0]   cap_idx;
    logic [R_AW-1:0]   cap_idx_nxt;
    logic              cap_en;
    logic              tmo_c;

    logic              wr_en;
    logic              wr_ibuf;
    logic              wr_wbuf;
    logic [BYTE_W-1:0] i_byte_nxt;

    logic [BYTE_W-1:0] ibuf [I_DEPTH];
    logic [BYTE_W-1:0] wbuf [W_DEPTH];
    logic [WORD_W-1:0] rbuf [R_DEPTH];

    // Buffer loads are accepted only in IDLE; 0-127 input bytes, 128-135 weights.
    assign wr_en   = ld_en && (state == S_IDLE);
    assign wr_ibuf = wr_en && !ld_addr[7];
    assign wr_wbuf = wr_en && (ld_addr[7:3] == 5'b10000);

    // Forward a same-cycle load so a start issued with a write streams the new byte.
    assign i_byte_nxt = (wr_ibuf && (ld_addr[I_AW-1:0] == i_cnt_nxt)) ? ld_data
                                                                    : ibuf[i_cnt_nxt];

    assign res_data = rbuf[res_addr];

`ifdef DCS_TIMEOUT_EN
    localparam int unsigned WDOG_W     = 6;
    localparam int unsigned WDOG_LIMIT = 63;

    logic [WDOG_W-1:0] wdog;
    logic              in_wait;
    logic              tmo_fire;
    logic              start_acc;

    assign in_wait   = (state == S_WAIT_WR) || (state == S_WAIT_O);
    // Fires on the 63rd consecutive waiting cycle without progress.
    assign tmo_c     = in_wait && (wdog == WDOG_W'(WDOG_LIMIT - 1));
    assign tmo_fire  = tmo_c && (((state == S_WAIT_WR) && !w_ready) ||
                                 ((state == S_WAIT_O)  && !o_valid));
    assign start_acc = (state == S_IDLE) && start;

    // Watchdog restarts on every state change and every result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if ((state_nxt != state) || cap_en) begin
            wdog <= '0;
        end else if (in_wait) begin
            wdog <= wdog + WDOG_W'(1);
        end
    end

    // Sticky timeout flag, cleared by reset or the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (start_acc) begin
            timeout_err <= 1'b0;
        end else if (tmo_fire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_c       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State and sequencing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            i_cnt   <= '0;
            w_cnt   <= '0;
            cap_idx <= '0;
        end else begin
            state   <= state_nxt;
            i_cnt   <= i_cnt_nxt;
            w_cnt   <= w_cnt_nxt;
            cap_idx <= cap_idx_nxt;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_nxt   = state;
        i_cnt_nxt   = i_cnt;
        w_cnt_nxt   = w_cnt;
        cap_idx_nxt = cap_idx;
        cap_en      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_SEND_I;
                    i_cnt_nxt   = '0;
                    cap_idx_nxt = '0;
                end
            end
            S_SEND_I: begin
                if (i_cnt == I_AW'(I_DEPTH - 1)) begin
                    state_nxt = S_WAIT_WR;
                end else begin
                    i_cnt_nxt = i_cnt + I_AW'(1);
                end
            end
            S_WAIT_WR: begin
                if (w_ready) begin
                    state_nxt = S_SEND_W;
                    w_cnt_nxt = '0;
                end else if (tmo_c) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SEND_W: begin
                if (w_cnt == W_AW'(W_DEPTH - 1)) begin
                    state_nxt = S_WAIT_O;
                end else begin
                    w_cnt_nxt = w_cnt + W_AW'(1);
                end
            end
            S_WAIT_O: begin
                if (o_valid) begin
                    cap_en      = 1'b1;
                    cap_idx_nxt = cap_idx + R_AW'(1);
                    if (cap_idx == R_AW'(R_DEPTH - 1)) begin
                        state_nxt = S_DONE;
                    end
                end else if (tmo_c) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered status and stream outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            i_valid <= 1'b0;
            i_data  <= '0;
            w_valid <= 1'b0;
            w_data  <= '0;
        end else begin
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_DONE);
            i_valid <= (state_nxt == S_SEND_I);
            i_data  <= (state_nxt == S_SEND_I) ? i_byte_nxt : '0;
            w_valid <= (state_nxt == S_SEND_W);
            w_data  <= (state_nxt == S_SEND_W) ? wbuf[w_cnt_nxt] : '0;
        end
    end

    // Input/weight/result storage; all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(I_DEPTH); k++) begin
                ibuf[k] <= '0;
            end
            for (int j = 0; j < int'(W_DEPTH); j++) begin
                wbuf[j] <= '0;
            end
            for (int n = 0; n < int'(R_DEPTH); n++) begin
                rbuf[n] <= '0;
            end
        end else begin
            if (wr_ibuf) begin
                ibuf[ld_addr[I_AW-1:0]] <= ld_data;
            end
            if (wr_wbuf) begin
                wbuf[ld_addr[W_AW-1:0]] <= ld_data;
            end
            if (cap_en) begin
                rbuf[cap_idx] <= o_data;
            end
        end
    end

endmodule

// File: tb/tb_dcs_host.sv
// tb_dcs_host: randomized self-checking bench for dcs_host with a buffer-level
// reference model (expected streams are read straight from model arrays).
module tb_dcs_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [2:0]  res_addr;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        w_ready;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        o_valid;
    logic [31:0] o_data;

    always #5 clk = ~clk;

    dcs_host dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .w_ready     (w_ready),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .o_valid     (o_valid),
        .o_data      (o_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ibuf_m [128];
    logic [7:0]  wbuf_m [8];
    logic [31:0] rbuf_m [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 128; k++) ibuf_m[k] = 8'h00;
        for (int j = 0; j < 8; j++)   wbuf_m[j] = 8'h00;
        for (int n = 0; n < 8; n++)   rbuf_m[n] = 32'h0;
    endtask

    // Model of an idle-time load: only 0..135 land anywhere.
    task automatic model_load(input int a, input logic [7:0] d);
        if (a < 128)      ibuf_m[a] = d;
        else if (a < 136) wbuf_m[a - 128] = d;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = 8'(a);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        model_load(a, d);
    endtask

    task automatic check_rbuf_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            res_addr = 3'(a);
            #1;
            check(tag, res_data, rbuf_m[a]);
        end
    endtask

    task automatic start_txn(input bit with_ld);
        int a;
        logic [7:0] d;
        if (with_ld) begin
            a       = int'($urandom_range(0, 127));
            d       = 8'($urandom_range(0, 255));
            ld_en   = 1'b1;
            ld_addr = 8'(a);
            ld_data = d;
            model_load(a, d);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        check("busy_after_start", busy, 1);
        check("tmo_clear_on_start", timeout_err, 0);
    endtask

    // 128 input beats; one random cycle carries stray w_ready/o_valid/ld/start.
    task automatic send_i_phase();
        int inj;
        inj = int'($urandom_range(0, 127));
        for (int k = 0; k < 128; k++) begin
            w_ready = 1'b0;
            o_valid = 1'b0;
            ld_en   = 1'b0;
            start   = 1'b0;
            check("i_valid", i_valid, 1);
            check("i_data", i_data, ibuf_m[k]);
            check("w_valid_in_send_i", w_valid, 0);
            if (k == inj) begin
                w_ready = 1'b1;
                o_valid = 1'b1;
                o_data  = $urandom;
                ld_en   = 1'b1;
                ld_addr = 8'd5;
                ld_data = 8'hFF;
                start   = 1'b1;
            end
            tick();
        end
        w_ready = 1'b0;
        o_valid = 1'b0;
        ld_en   = 1'b0;
        start   = 1'b0;
        check("i_valid_end", i_valid, 0);
        check("i_data_end", i_data, 0);
        check("busy_wait_wr", busy, 1);
        check("w_valid_wait_wr", w_valid, 0);
        check_rbuf_all("rbuf_kept_send_i");
    endtask

    task automatic send_w_phase(input int nb);
        int wt;
        wt = int'($urandom_range(0, 4));
        repeat (wt) begin
            check("w_valid_idle_wait", w_valid, 0);
            check("busy_idle_wait", busy, 1);
            tick();
        end
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        for (int j = 0; j < nb; j++) begin
            check("w_valid", w_valid, 1);
            check("w_data", w_data, 32'(wbuf_m[j]));
            check("i_valid_in_send_w", i_valid, 0);
            tick();
        end
        if (nb == 8) begin
            check("w_valid_end", w_valid, 0);
            check("w_data_end", w_data, 0);
            check("busy_wait_o", busy, 1);
        end
    endtask

    task automatic recv_o_phase(input bit directed);
        int gap;
        logic [31:0] d;
        for (int n = 0; n < 8; n++) begin
            if (directed) gap = (n == 4) ? 1 : 0;
            else          gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                o_valid = 1'b0;
                o_data  = $urandom;
                tick();
                check("done_in_gap", done, 0);
            end
            d = directed ? 32'(100 + n) : $urandom;
            o_valid = 1'b1;
            o_data  = d;
            rbuf_m[n] = d;
            tick();
            o_valid = 1'b0;
            if (n < 7) begin
                check("done_early", done, 0);
                check("busy_wait_o", busy, 1);
                res_addr = 3'(n);
                #1;
                check("res_data_live", res_data, d);
            end
        end
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        o_valid = 1'b1;
        o_data  = 32'hDEAD_BEEF;
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        tick();
        o_valid = 1'b0;
        check("done_idle", done, 0);
        check("no_second_txn", busy, 0);
        check_rbuf_all("rbuf_final");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = 8'h00;
        ld_data  = 8'h00;
        res_addr = 3'd0;
        w_ready  = 1'b0;
        o_valid  = 1'b0;
        o_data   = 32'h0;
        model_clear();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_i_valid", i_valid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_i_data", i_data, 0);
        check("rst_w_data", w_data, 0);
        check("rst_tmo", timeout_err, 0);
        rst = 1'b0;
        check_rbuf_all("rst_rbuf");

        // Directed transaction: ibuf[k]=k, wbuf[j]=j+1, results 100..107.
        for (int k = 0; k < 128; k++) load(k, 8'(k));
        for (int j = 0; j < 8; j++)   load(128 + j, 8'(j + 1));
        load(136, 8'hDD);
        load(200, 8'hEE);
        load(255, 8'h77);
        tick();
        start_txn(1'b0);
        send_i_phase();
        send_w_phase(8);
        recv_o_phase(1'b1);

        // Random partial reload, start with same-cycle load.
        repeat (20) load(int'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        start_txn(1'b1);
        send_i_phase();
        send_w_phase(8);
        recv_o_phase(1'b0);

        // Reset in the middle of the weight stream.
        start_txn(1'b1);
        send_i_phase();
        send_w_phase(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("rst_mid_w_valid", w_valid, 0);
        check("rst_mid_w_data", w_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_i_valid", i_valid, 0);
        check_rbuf_all("rst_mid_rbuf");
        repeat (3) begin
            tick();
            check("post_rst_w_valid", w_valid, 0);
            check("post_rst_busy", busy, 0);
        end

        // Full random reload and transaction.
        for (int a = 0; a < 136; a++) load(a, 8'($urandom_range(0, 255)));
        start_txn(1'b1);
        send_i_phase();
        send_w_phase(8);
        recv_o_phase(1'b0);

        // No w_ready: watchdog abort, or indefinite wait.
        start_txn(1'b0);
        send_i_phase();
`ifdef DCS_TIMEOUT_EN
        for (int t = 0; t < 63; t++) begin
            check("tmo_busy_wait", busy, 1);
            check("tmo_not_yet", timeout_err, 0);
            check("tmo_no_done", done, 0);
            tick();
        end
        check("tmo_idle", busy, 0);
        check("tmo_flag", timeout_err, 1);
        check("tmo_done", done, 0);
        tick();
        check("tmo_sticky", timeout_err, 1);
        start_txn(1'b0);
`else
        repeat (100) begin
            check("hold_busy", busy, 1);
            check("hold_tmo", timeout_err, 0);
            check("hold_w_valid", w_valid, 0);
            tick();
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_busy", busy, 0);
        check("final_tmo", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
